mem_stage: RTL

//  Pipeline MEM stage of the 5-stage MIPS core: consumes the EX/MEM register outputs (mem_* fields),

---
 rtl/cpu_types_pkg.sv | 24 ++
 rtl/mem_wb_reg.sv | 36 +++
 rtl/mem_stage.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/cpu_types_pkg.sv
// Shared types and encodings for the MIPS core pipeline stages.
package cpu_types_pkg;

  typedef logic [31:0] word_t;
  typedef logic [4:0]  regbits_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    HALTED = 2'd2
  } memstage_state_t;

  // MemtoReg select for the writeback value (3 behaves as ALU)
  localparam logic [1:0] MTR_ALU = 2'd0;
  localparam logic [1:0] MTR_MEM = 2'd1;
  localparam logic [1:0] MTR_PC4 = 2'd2;

  // PCSrc select for the next-PC redirect
  localparam logic [1:0] PC_SEQ = 2'd0;
  localparam logic [1:0] PC_BR  = 2'd1;
  localparam logic [1:0] PC_J   = 2'd2;
  localparam logic [1:0] PC_JR  = 2'd3;

endpackage

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline latch: captures a retiring instruction, inserts a bubble
// (RegWr=0) on any non-retiring cycle and keeps a sticky halt flag.
module mem_wb_reg
  import cpu_types_pkg::*;
(
  input  logic     CLK,
  input  logic     nRST,
  input  logic     retire,
  input  logic     halt_set,
  input  logic     reg_wr,
  input  regbits_t wsel,
  input  word_t    wdat,
  output logic     wb_RegWr,
  output regbits_t wb_wsel,
  output word_t    wb_wdat,
  output logic     wb_halt
);

  // Latch on retire, otherwise hold data and emit a bubble
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      wb_RegWr <= 1'b0;
      wb_wsel  <= '0;
      wb_wdat  <= '0;
      wb_halt  <= 1'b0;
    end else begin
      wb_RegWr <= retire & reg_wr;
      if (retire) begin
        wb_wsel <= wsel;
        wb_wdat <= wdat;
      end
      if (halt_set) wb_halt <= 1'b1;
    end
  end

endmodule

// File: rtl/mem_stage.sv
// MEM stage of the 5-stage MIPS core: data-cache handshake, branch/jump
// redirect resolution and MEM/WB latch update.
// Optional macro MEM_STAGE_FWD_EN adds fwd_valid/fwd_wsel/fwd_data outputs
// exposing the retiring value to EX forwarding.
module mem_stage
  import cpu_types_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic        CLK,
  input  logic        nRST,
  input  word_t       mem_pc_4,
  input  word_t       mem_branch_addr,
  input  logic [27:0] mem_jump_addr,
  input  word_t       mem_rdat1,
  input  word_t       mem_rdat2,
  input  word_t       mem_alu_out,
  input  regbits_t    mem_wsel,
  input  logic        mem_MemRd,
  input  logic        mem_MemWr,
  input  logic        mem_branch,
  input  logic        mem_zero,
  input  logic [1:0]  mem_PCSrc,
  input  logic        mem_RegWr,
  input  logic [1:0]  mem_MemtoReg,
  input  logic        mem_halt,
  input  logic        dhit,
  input  word_t       dmemload,
  output logic        dmemREN,
  output logic        dmemWEN,
  output word_t       dmemaddr,
  output word_t       dmemstore,
  output logic        mem_stall,
  output logic        pc_redirect,
  output word_t       redirect_addr,
  output logic        wb_RegWr,
  output regbits_t    wb_wsel,
  output word_t       wb_wdat,
  output logic        wb_halt,
  output logic        mem_err
`ifdef MEM_STAGE_FWD_EN
  ,
  output logic        fwd_valid,
  output regbits_t    fwd_wsel,
  output word_t       fwd_data
`endif
);

  memstage_state_t state;
  logic [7:0]      wdog;
  logic            req;
  logic            retire;
  logic            halt_now;
  word_t           wdat;

  function automatic word_t wb_mux(input logic [1:0] mtr, input word_t alu,
                                   input word_t ld, input word_t pc4);
    case (mtr)
      MTR_MEM: wb_mux = ld;
      MTR_PC4: wb_mux = pc4;
      default: wb_mux = alu;
    endcase
  endfunction

  assign wdat = wb_mux(mem_MemtoReg, mem_alu_out, dmemload, mem_pc_4);

  // Request, stall, retire and redirect decode; everything is quiet in reset
  always_comb begin
    req           = 1'b0;
    retire        = 1'b0;
    halt_now      = 1'b0;
    mem_stall     = 1'b0;
    dmemREN       = 1'b0;
    dmemWEN       = 1'b0;
    dmemaddr      = '0;
    dmemstore     = '0;
    pc_redirect   = 1'b0;
    redirect_addr = '0;
    if (nRST) begin
      case (state)
        IDLE: begin
          if (mem_halt)                    halt_now = 1'b1;
          else if (mem_MemRd || mem_MemWr) req      = 1'b1;
          else                             retire   = 1'b1;
        end
        ACCESS:  req       = 1'b1;
        default: mem_stall = 1'b1;
      endcase
      if (req) begin
        // a combined read+write is a store; never both requests at once
        dmemWEN   = mem_MemWr;
        dmemREN   = mem_MemRd & ~mem_MemWr;
        dmemaddr  = mem_alu_out;
        dmemstore = mem_rdat2;
        mem_stall = ~dhit;
        retire    = dhit;
      end
      if (retire) begin
        case (mem_PCSrc)
          PC_BR: begin
            pc_redirect   = mem_branch & mem_zero;
            redirect_addr = mem_branch_addr;
          end
          PC_J: begin
            pc_redirect   = 1'b1;
            redirect_addr = {mem_pc_4[31:28], mem_jump_addr};
          end
          PC_JR: begin
            pc_redirect   = 1'b1;
            redirect_addr = mem_rdat1;
          end
          default: ;
        endcase
        if (!pc_redirect) redirect_addr = '0;
      end
    end
  end

  // Stage FSM plus access watchdog and sticky error flag
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state   <= IDLE;
      wdog    <= '0;
      mem_err <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (halt_now)         state <= HALTED;
          else if (req && !dhit) state <= ACCESS;
        end
        ACCESS:  if (dhit) state <= IDLE;
        HALTED:  state <= HALTED;
        default: state <= IDLE;
      endcase
      if (req && !dhit) begin
        if (wdog != 8'hFF) wdog <= wdog + 8'd1;
        if (32'(wdog) + 32'd1 >= TIMEOUT_CYC) mem_err <= 1'b1;
      end else begin
        wdog <= '0;
      end
    end
  end

  mem_wb_reg u_mem_wb_reg (
    .CLK      (CLK),
    .nRST     (nRST),
    .retire   (retire),
    .halt_set (halt_now),
    .reg_wr   (mem_RegWr),
    .wsel     (mem_wsel),
    .wdat     (wdat),
    .wb_RegWr (wb_RegWr),
    .wb_wsel  (wb_wsel),
    .wb_wdat  (wb_wdat),
    .wb_halt  (wb_halt)
  );

`ifdef MEM_STAGE_FWD_EN
  assign fwd_valid = retire & mem_RegWr & (mem_wsel != '0);
  assign fwd_wsel  = mem_wsel;
  assign fwd_data  = wdat;
`endif

endmodule
